// File: rtl/coding_input_unpacker_if.sv
// Stream bundle for coding_input_unpacker: packed-word input, length commands
// and code output. output_error exists only with CODING_INPUT_UNPACKER_ERROR_EN.
interface coding_input_unpacker_if #(
  parameter int CODE_WIDTH      = 39,
  parameter int BIT_AMT_WIDTH   = 6,
  parameter int INPUT_WIDTH_LOG = 5
);
  localparam int W = 1 << INPUT_WIDTH_LOG;

  logic [W-1:0]             input_data;
  logic                     input_valid;
  logic                     input_ready;
  logic                     input_last;
  logic [BIT_AMT_WIDTH-1:0] input_length_data;
  logic                     input_length_valid;
  logic                     input_length_ready;
  logic                     input_length_last;
  logic [CODE_WIDTH-1:0]    output_code_data;
  logic                     output_valid;
  logic                     output_ready;
  logic                     output_last;
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
  logic                     output_error;
`endif

  modport slave (
    input  input_data, input_valid, input_last,
    input  input_length_data, input_length_valid, input_length_last,
    input  output_ready,
    output input_ready, input_length_ready,
    output output_code_data, output_valid, output_last
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
    , output output_error
`endif
  );

  modport master (
    output input_data, input_valid, input_last,
    output input_length_data, input_length_valid, input_length_last,
    output output_ready,
    input  input_ready, input_length_ready,
    input  output_code_data, output_valid, output_last
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
    , input output_error
`endif
  );
endinterface

// File: rtl/coding_input_unpacker.sv
// Bitstream reader: consumes MSB-first packed words and returns one
// right-aligned, zero-extended code per length command.
// Optional macro CODING_INPUT_UNPACKER_ERROR_EN adds output_error, flagging
// codes produced by underflow or by a clamped (over-long) length command.
module coding_input_unpacker #(
  parameter int CODE_WIDTH      = 39,
  parameter int BIT_AMT_WIDTH   = 6,
  parameter int INPUT_WIDTH_LOG = 5
) (
  input logic                    clk,
  input logic                    rst,
  coding_input_unpacker_if.slave bus
);
  localparam int W      = 1 << INPUT_WIDTH_LOG;
  localparam int BUF_W  = CODE_WIDTH + W;
  localparam int FILL_W = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {S_FILL, S_FLUSH, S_FLUSH_WAIT} state_t;

  // Buffer is MSB-aligned: the oldest bit sits at bit BUF_W-1, bits below fill are 0.
  logic [BUF_W-1:0]      bits_q, bits_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  last_loaded_q, last_loaded_d;
  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [CODE_WIDTH-1:0] out_code_q, out_code_d;
  logic                  out_last_q, out_last_d;
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
  logic                  out_err_q, out_err_d;
`endif

  logic                     cmd_over;
  logic [BIT_AMT_WIDTH-1:0] len_c;
  logic [FILL_W-1:0]        len_f;
  logic                     underflow;
  logic                     out_free;
  logic                     word_ok;
  logic                     in_rdy;
  logic                     cmd_rdy;
  logic                     word_fire;
  logic                     cmd_fire;
  logic [BUF_W-1:0]         code_wide;
  logic [BUF_W-1:0]         bits_after;
  logic [FILL_W-1:0]        fill_after;
  logic [BUF_W-1:0]         word_ext;

  // Handshake decisions and the extract-then-append datapath.
  always_comb begin
    cmd_over  = bus.input_length_data > BIT_AMT_WIDTH'(CODE_WIDTH);
    len_c     = cmd_over ? BIT_AMT_WIDTH'(CODE_WIDTH) : bus.input_length_data;
    len_f     = FILL_W'(len_c);
    underflow = len_f > fill_q;
    out_free  = !out_valid_q || bus.output_ready;
    word_ok   = (fill_q <= FILL_W'(CODE_WIDTH)) && !last_loaded_q;

    in_rdy = 1'b0;
    case (state_q)
      S_FILL, S_FLUSH: in_rdy = word_ok;
      S_FLUSH_WAIT:    in_rdy = 1'b1;
      default:         in_rdy = 1'b0;
    endcase
    in_rdy  = in_rdy && rst;
    cmd_rdy = rst && (state_q == S_FILL) && (!underflow || last_loaded_q) && out_free;

    word_fire = in_rdy && bus.input_valid;
    cmd_fire  = cmd_rdy && bus.input_length_valid;

    // Shift by BUF_W when len=0 yields an all-zero code.
    code_wide  = bits_q >> (FILL_W'(BUF_W) - len_f);
    bits_after = cmd_fire ? (bits_q << len_f) : bits_q;
    fill_after = !cmd_fire ? fill_q : (underflow ? '0 : fill_q - len_f);
    // The new word lands directly below whatever survives this cycle's extraction.
    word_ext   = {bus.input_data, {CODE_WIDTH{1'b0}}} >> fill_after;
  end

  // Next-state for the flow FSM, bit buffer and output register.
  always_comb begin
    state_d       = state_q;
    bits_d        = bits_q;
    fill_d        = fill_q;
    last_loaded_d = last_loaded_q;
    out_valid_d   = out_valid_q;
    out_code_d    = out_code_q;
    out_last_d    = out_last_q;
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
    out_err_d     = out_err_q;
`endif

    case (state_q)
      S_FILL: begin
        bits_d = bits_after;
        fill_d = fill_after;
        if (word_fire) begin
          bits_d = bits_after | word_ext;
          fill_d = fill_after + FILL_W'(W);
          if (bus.input_last) last_loaded_d = 1'b1;
        end
        if (cmd_fire && bus.input_length_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Whatever is buffered belongs to the finished stream.
        bits_d        = '0;
        fill_d        = '0;
        last_loaded_d = 1'b0;
        if (last_loaded_q || (word_fire && bus.input_last)) state_d = S_FILL;
        else                                                state_d = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (word_fire && bus.input_last) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase

    if (cmd_fire) begin
      out_valid_d = 1'b1;
      out_code_d  = code_wide[CODE_WIDTH-1:0];
      out_last_d  = bus.input_length_last;
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
      out_err_d   = (underflow && last_loaded_q) || cmd_over;
`endif
    end else if (bus.output_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FILL;
      bits_q        <= '0;
      fill_q        <= '0;
      last_loaded_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_code_q    <= '0;
      out_last_q    <= 1'b0;
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
      out_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bits_q        <= bits_d;
      fill_q        <= fill_d;
      last_loaded_q <= last_loaded_d;
      out_valid_q   <= out_valid_d;
      out_code_q    <= out_code_d;
      out_last_q    <= out_last_d;
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
      out_err_q     <= out_err_d;
`endif
    end
  end

  assign bus.input_ready        = in_rdy;
  assign bus.input_length_ready = cmd_rdy;
  assign bus.output_valid       = out_valid_q;
  assign bus.output_code_data   = out_code_q;
  assign bus.output_last        = out_last_q;
`ifdef CODING_INPUT_UNPACKER_ERROR_EN
  assign bus.output_error       = out_err_q;
`endif
endmodule

// File: doc/coding_input_unpacker.md
Name: coding_input_unpacker

Overview:
- Bitstream reader; the receive-side counterpart of coding_output_packer.
- Consumes the fixed-width, MSB-first packed word stream and returns variable-length codes, one per length command. Each code is right-aligned and zero-extended.
- Sits at the head of the decoder, in front of the entropy decoders, which issue a length per field.

Parameters:
CODE_WIDTH, 39, max code length and output code width
BIT_AMT_WIDTH, 6, width of the length command
INPUT_WIDTH_LOG, 5, packed word width W = 2**INPUT_WIDTH_LOG

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
input_data  in  W  packed word, MSB is the oldest bit
input_valid  in  1  AXIS valid, word side
input_ready  out  1  AXIS ready, word side
input_last  in  1  final word of the stream (includes zero padding)
input_length_data  in  BIT_AMT_WIDTH  number of bits to extract, 0..CODE_WIDTH
input_length_valid  in  1  AXIS valid, command side
input_length_ready  out  1  AXIS ready, command side
input_length_last  in  1  final code of the stream
output_code_data  out  CODE_WIDTH  extracted code, right-aligned
output_valid  out  1  AXIS valid, code side
output_ready  in  1  AXIS ready, code side
output_last  out  1  copy of input_length_last for this code

Behaviour:
- Reset: while rst=0, all state clears asynchronously.
  - Bit buffer (CODE_WIDTH+W bits) = 0, fill counter = 0, state = FILL, last_loaded = 0.
  - Outputs: output_valid=0, output_code_data=0, output_last=0, input_ready=0, input_length_ready=0.
  - A reset mid-operation discards buffered bits and any held code.
- Word acceptance: input_ready=1 when fill <= CODE_WIDTH, last_loaded=0 and state != FLUSH_WAIT.
  - An accepted word is appended below the current fill; fill += W.
  - If input_last is set on the accepted word, last_loaded is set.
- Command acceptance: input_length_ready=1 in FILL when all of:
  - fill >= input_length_data, or last_loaded=1;
  - the output register is empty, or output_ready=1.
  - Only bits already buffered count; a word arriving in the same cycle does not.
- Extraction:
  - The oldest len bits form the code, right-aligned, with upper bits zero; fill -= len.
  - The code, with output_last, is registered: output_valid rises 1 cycle after command acceptance.
  - The output register is held stable while output_valid=1 and output_ready=0.
- Arithmetic:
  - Same-cycle word accept and extract: fill_next = fill + W - len.
  - The fill counter width is clog2(CODE_WIDTH+W+1).
  - len > CODE_WIDTH is illegal; hardware clamps it to CODE_WIDTH.
- len = 0 is accepted whenever the output register is free and yields code 0. output_last is still honoured.
- Underflow: if last_loaded=1 and len > fill, missing bits are taken as 0 and fill becomes 0.
- States:
  - FILL: normal operation.
  - FLUSH: entered after accepting a command with input_length_last=1.
    - If last_loaded=1, the buffer is discarded (padding dropped), fill=0, last_loaded=0; return to FILL next cycle.
    - Otherwise go to FLUSH_WAIT.
  - FLUSH_WAIT: input_ready=1 and incoming words are dropped. The word carrying input_last is dropped too, then FILL.
  - The next stream always starts word-aligned.
- No bits are lost or duplicated under arbitrary valid/ready gaps on any port.

Optional Feature:
- Macro: CODING_INPUT_UNPACKER_ERROR_EN.
- Defined:
  - Adds port output_error (out, 1), registered alongside output_code_data.
  - output_error=1 on a code produced by underflow.
  - output_error=1 on a code whose command was clamped (len > CODE_WIDTH).
  - Reset value 0.
- Undefined: the port is absent; underflow and clamp behaviour are unchanged, and no error is reported.

Test Plan:
- Aligned extraction: words 0x12345678, 0x9ABCDEF0; lengths 4, 8, 24, 0, 28 -> codes 0x1, 0x23, 0x456789, 0x0, 0xABCDEF0, in order.
- Round-trip: feed coding_output_packer output for (10028,27), (-14650,14), (-4444,14), (-16370,14), (-8172,13), (-8155,13), (-8125,13), (-8151,13).
  - Commands are the same lengths.
  - Each code equals the input masked to its length, e.g. 10028, then 1734.
- Flush: word 0xF0000000 with input_last; command len 4 with input_length_last -> code 0xF, output_last=1, remaining 28 bits discarded.
  - Then word 0xA0000000, len 4 -> 0xA.
  - Early last: command last before the input_last word arrives -> words dropped through input_last.
- Backpressure: output_ready held 0 for 5 cycles with a code pending.
  - output_code_data stays stable and input_length_ready=0.
  - A random valid/ready drain yields the same code sequence as the aligned-extraction case.
- Underflow (macro defined): word 0x80000000 with last, len 33 -> code 0x100000000, output_error=1.
  - Macro undefined: same code, no error port.
- Reset: rst=0 pulse asynchronously mid-clock while fill=20 and output_valid=1.
  - output_valid=0 immediately and fill=0.
  - After release, a new stream decodes correctly from bit 0.
